// File: rtl/hazard_pkg.sv
// Shared widths and named issue latencies for the hazard scoreboard slice.
package hazard_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;
    localparam int LAT_W    = 3;
    localparam int CNT_W    = 32;

    localparam logic [LAT_W-1:0] LAT_ALU  = 3'd0;
    localparam logic [LAT_W-1:0] LAT_LOAD = 3'd1;
    localparam logic [LAT_W-1:0] LAT_MUL  = 3'd3;
    localparam logic [LAT_W-1:0] LAT_DIV  = 3'd7;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decoder / issue / writeback bundle between the ID stage control and the scoreboard.
interface hazard_scoreboard_if;
    import hazard_pkg::*;

    logic                    issue_valid_i;
    logic                    issue_regwrite_i;
    logic [REG_W-1:0]        issue_rd_i;
    logic [LAT_W-1:0]        issue_lat_i;
    logic                    flush_i;
    logic [REG_W-1:0]        id_rs1_i;
    logic [REG_W-1:0]        id_rs2_i;
    logic                    id_use_rs1_i;
    logic                    id_use_rs2_i;
    logic                    wb_valid_i;
    logic [REG_W-1:0]        wb_rd_i;
    logic                    stall_o;
    logic [NUM_REGS-1:0]     busy_o;
    logic [CNT_W-1:0]        stall_cnt_o;

    modport master (
        output issue_valid_i, issue_regwrite_i, issue_rd_i, issue_lat_i, flush_i,
               id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, wb_valid_i, wb_rd_i,
        input  stall_o, busy_o, stall_cnt_o
    );

    modport slave (
        input  issue_valid_i, issue_regwrite_i, issue_rd_i, issue_lat_i, flush_i,
               id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, wb_valid_i, wb_rd_i,
        output stall_o, busy_o, stall_cnt_o
    );

endinterface

// File: rtl/scoreboard_entry.sv
// One tracked register: pending flag plus a countdown of cycles until its value can be forwarded.
module scoreboard_entry
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [LAT_W-1:0] set_lat,
    input  logic             clear,
    output logic             pending,
    output logic             wait_nz
);

    logic [LAT_W-1:0] cnt;

    // A new producer supersedes an older one retiring in the same cycle, so set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            cnt     <= '0;
        end else if (set) begin
            pending <= 1'b1;
            cnt     <= set_lat;
        end else if (clear) begin
            pending <= 1'b0;
            cnt     <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign wait_nz = pending && (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers and stalls ID until a producer's result is forwardable.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_scoreboard_if.slave   bus
);

    logic [NUM_REGS-1:0] pending_vec;
    logic [NUM_REGS-1:0] wait_vec;
    logic                stall;
    logic                issue_accept;
    logic                wb_accept;
    logic [CNT_W-1:0]    stall_cnt;

    // x0 is hardwired, so it never waits and never reports busy.
    assign pending_vec[0] = 1'b0;
    assign wait_vec[0]    = 1'b0;

    assign issue_accept = bus.issue_valid_i && bus.issue_regwrite_i && !stall
                          && !bus.flush_i && (bus.issue_rd_i != '0);
    assign wb_accept    = bus.wb_valid_i && (bus.wb_rd_i != '0);

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        logic set_hit;
        logic clear_hit;

        assign set_hit   = issue_accept && (bus.issue_rd_i == REG_W'(i));
        assign clear_hit = wb_accept && (bus.wb_rd_i == REG_W'(i));

        scoreboard_entry u_entry (
            .clk     (clk_i),
            .rst     (rst_i),
            .set     (set_hit),
            .set_lat (bus.issue_lat_i),
            .clear   (clear_hit),
            .pending (pending_vec[i]),
            .wait_nz (wait_vec[i])
        );
    end

    assign stall = (bus.id_use_rs1_i && (bus.id_rs1_i != '0) && wait_vec[bus.id_rs1_i])
                || (bus.id_use_rs2_i && (bus.id_rs2_i != '0) && wait_vec[bus.id_rs2_i]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.stall_o     = stall;
    assign bus.busy_o      = pending_vec;
    assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed test-plan scenarios plus random traffic checked against a ready-time reference model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if bus ();

    hazard_scoreboard dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus for the next cycle, filled by the scenarios before applyStimulus.
    logic             s_rst, s_issue_valid, s_regwrite, s_flush, s_use1, s_use2, s_wb_valid;
    logic [REG_W-1:0] s_rd, s_rs1, s_rs2, s_wb_rd;
    logic [LAT_W-1:0] s_lat;

    // Reference: a producer is pending until writeback and forwardable from cycle m_ready onward.
    bit              m_pending [NUM_REGS];
    int              m_ready   [NUM_REGS];
    int              m_now;
    int unsigned     m_cnt;

    logic             seen_stall;
    logic [31:0]      seen_busy;
    logic [31:0]      seen_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit modelWaits(input logic [REG_W-1:0] r, input logic use_it);
        return use_it && (r != 0) && m_pending[r] && (m_now < m_ready[r]);
    endfunction

    function automatic bit modelStall();
        return modelWaits(s_rs1, s_use1) || modelWaits(s_rs2, s_use2);
    endfunction

    function automatic logic [31:0] modelBusy();
        logic [31:0] b = '0;
        for (int r = 1; r < NUM_REGS; r++) b[r] = m_pending[r];
        return b;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_pending[r] = 0;
            m_ready[r]   = 0;
        end
        m_cnt = 0;
    endtask

    task automatic clearStim();
        s_rst = 0; s_issue_valid = 0; s_regwrite = 0; s_flush = 0;
        s_use1 = 0; s_use2 = 0; s_wb_valid = 0;
        s_rd = '0; s_rs1 = '0; s_rs2 = '0; s_wb_rd = '0; s_lat = '0;
    endtask

    // One cycle: drive at negedge, compare just after, advance the model at the posedge.
    task automatic applyStimulus();
        bit m_stall;
        bit accept;
        @(negedge clk);
        rst                  = s_rst;
        bus.issue_valid_i    = s_issue_valid;
        bus.issue_regwrite_i = s_regwrite;
        bus.issue_rd_i       = s_rd;
        bus.issue_lat_i      = s_lat;
        bus.flush_i          = s_flush;
        bus.id_rs1_i         = s_rs1;
        bus.id_rs2_i         = s_rs2;
        bus.id_use_rs1_i     = s_use1;
        bus.id_use_rs2_i     = s_use2;
        bus.wb_valid_i       = s_wb_valid;
        bus.wb_rd_i          = s_wb_rd;
        #1;
        m_stall    = modelStall();
        seen_stall = bus.stall_o;
        seen_busy  = bus.busy_o;
        seen_cnt   = bus.stall_cnt_o;
        checkOutput("stall", {31'b0, seen_stall}, {31'b0, m_stall});
        checkOutput("busy", seen_busy, modelBusy());
        checkOutput("stall_cnt", seen_cnt, m_cnt);
        checkOutput("issue_while_stall", {31'b0, s_issue_valid & seen_stall}, 32'd0);
        @(posedge clk);
        if (s_rst) begin
            modelReset();
        end else begin
            if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
            accept = s_issue_valid && s_regwrite && !m_stall && !s_flush && (s_rd != 0);
            if (s_wb_valid && s_wb_rd != 0) m_pending[s_wb_rd] = 0;
            if (accept) begin
                m_pending[s_rd] = 1;
                m_ready[s_rd]   = m_now + 1 + int'(s_lat);
            end
        end
        m_now++;
    endtask

    task automatic resetCycle();
        clearStim();
        s_rst = 1;
        applyStimulus();
        clearStim();
    endtask

    task automatic issue(input logic [REG_W-1:0] rd, input logic [LAT_W-1:0] lat);
        s_issue_valid = 1; s_regwrite = 1; s_rd = rd; s_lat = lat;
    endtask

    initial begin
        int stalls;
        clearStim();
        modelReset();
        m_now = 0;
        rst = 1;
        bus.issue_valid_i = 0; bus.issue_regwrite_i = 0; bus.issue_rd_i = '0;
        bus.issue_lat_i = '0; bus.flush_i = 0; bus.id_rs1_i = '0; bus.id_rs2_i = '0;
        bus.id_use_rs1_i = 0; bus.id_use_rs2_i = 0; bus.wb_valid_i = 0; bus.wb_rd_i = '0;
        @(posedge clk);
        m_now = 1;

        clearStim();
        applyStimulus();
        checkOutput("reset_busy", seen_busy, 32'd0);
        checkOutput("reset_stall_cnt", seen_cnt, 32'd0);

        // Load-use: exactly one bubble.
        resetCycle();
        issue(5'd5, LAT_LOAD); applyStimulus();
        clearStim(); s_rs1 = 5'd5; s_use1 = 1; applyStimulus();
        checkOutput("load_use_stall", {31'b0, seen_stall}, 32'd1);
        applyStimulus();
        checkOutput("load_use_release", {31'b0, seen_stall}, 32'd0);
        checkOutput("load_use_cnt", seen_cnt, 32'd1);

        // ALU producer: no stall, busy until writeback.
        resetCycle();
        issue(5'd7, LAT_ALU); applyStimulus();
        clearStim(); s_rs1 = 5'd7; s_use1 = 1; applyStimulus();
        checkOutput("alu_no_stall", {31'b0, seen_stall}, 32'd0);
        checkOutput("alu_busy", {31'b0, seen_busy[7]}, 32'd1);
        clearStim(); s_wb_valid = 1; s_wb_rd = 5'd7; applyStimulus();
        clearStim(); applyStimulus();
        checkOutput("alu_busy_clear", {31'b0, seen_busy[7]}, 32'd0);

        // Divide: seven stall cycles on rs2.
        resetCycle();
        issue(5'd9, LAT_DIV); applyStimulus();
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            clearStim(); s_rs2 = 5'd9; s_use2 = 1; applyStimulus();
            stalls += int'(seen_stall);
        end
        checkOutput("div_stall_cycles", stalls, 32'd7);
        checkOutput("div_stall_cnt", seen_cnt, 32'd7);
        clearStim(); s_wb_valid = 1; s_wb_rd = 5'd9; applyStimulus();
        checkOutput("div_busy_before_wb", {31'b0, seen_busy[9]}, 32'd1);
        clearStim(); applyStimulus();
        checkOutput("div_busy_after_wb", {31'b0, seen_busy[9]}, 32'd0);

        // Issue and writeback of x3 in the same cycle: issue wins.
        resetCycle();
        issue(5'd3, LAT_ALU); applyStimulus();
        clearStim(); issue(5'd3, 3'd2); s_wb_valid = 1; s_wb_rd = 5'd3; applyStimulus();
        stalls = 0;
        for (int k = 0; k < 3; k++) begin
            clearStim(); s_rs1 = 5'd3; s_use1 = 1; applyStimulus();
            stalls += int'(seen_stall);
            checkOutput("same_cycle_busy", {31'b0, seen_busy[3]}, 32'd1);
        end
        checkOutput("same_cycle_stalls", stalls, 32'd2);

        // rd = 0 and flushed issues leave the scoreboard untouched.
        resetCycle();
        issue(5'd0, LAT_DIV); applyStimulus();
        clearStim(); issue(5'd6, LAT_DIV); s_flush = 1; applyStimulus();
        clearStim(); s_rs1 = 5'd0; s_use1 = 1; s_rs2 = 5'd6; s_use2 = 1; applyStimulus();
        checkOutput("x0_flush_busy", seen_busy, 32'd0);
        checkOutput("x0_flush_stall", {31'b0, seen_stall}, 32'd0);

        // Reset in the middle of a lat-5 countdown.
        resetCycle();
        issue(5'd4, 3'd5); applyStimulus();
        clearStim(); s_rs1 = 5'd4; s_use1 = 1; applyStimulus(); applyStimulus();
        s_rst = 1; s_wb_valid = 1; s_wb_rd = 5'd4; applyStimulus();
        checkOutput("mid_rst_stalling", {31'b0, seen_stall}, 32'd1);
        s_rst = 0; s_wb_valid = 0; applyStimulus();
        checkOutput("mid_rst_busy", seen_busy, 32'd0);
        checkOutput("mid_rst_stall", {31'b0, seen_stall}, 32'd0);
        checkOutput("mid_rst_cnt", seen_cnt, 32'd0);

        // Random traffic concentrated on a few registers so hazards are frequent.
        for (int k = 0; k < 3000; k++) begin
            clearStim();
            s_rst      = ($urandom_range(0, 99) == 0);
            s_rs1      = 5'($urandom_range(0, 7));
            s_rs2      = 5'($urandom_range(0, 7));
            s_use1     = 1'($urandom);
            s_use2     = 1'($urandom);
            s_regwrite = ($urandom_range(0, 3) != 0);
            s_rd       = 5'($urandom_range(0, 7));
            s_lat      = 3'($urandom);
            s_flush    = ($urandom_range(0, 9) == 0);
            s_wb_valid = 1'($urandom);
            s_wb_rd    = 5'($urandom_range(0, 7));
            s_issue_valid = 1'($urandom) && !modelStall();
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer-side companion to the pipeline's operand-forwarding logic. It records each destination register at issue, counts down the cycles until that result can be forwarded, and stalls the ID stage when a source operand's producer cannot yet supply a value. Entries are released at writeback. It sits beside the ID/EX pipeline register, fed by the decoder, the ID/EX issue path and the MEM/WB writeback port.

## Interface
- NUM_REGS, 32, architectural registers; x0 is never tracked
- REG_W, 5, register index width
- LAT_W, 3, width of the issue latency / countdown field
- CNT_W, 32, width of the stall-cycle performance counter

- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- issue_valid_i  in  1  the instruction in ID advances into EX this cycle
- issue_regwrite_i  in  1  the issuing instruction writes rd
- issue_rd_i  in  REG_W  destination register of the issuing instruction
- issue_lat_i  in  LAT_W  stall cycles a dependant needs: 0 = ALU, 1 = load, up to 7 = multi-cycle unit
- flush_i  in  1  kill the instruction in ID; suppresses issue this cycle
- id_rs1_i, id_rs2_i  in  REG_W  source registers of the instruction in ID
- id_use_rs1_i, id_use_rs2_i  in  1  the corresponding source is actually read
- wb_valid_i  in  1  a register write retires this cycle
- wb_rd_i  in  REG_W  register written at writeback
- stall_o  out  1  hold PC and IF/ID, and insert a bubble into ID/EX
- busy_o  out  NUM_REGS  per-register pending bit; bit 0 is always 0
- stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o = 1

## Operation
- Per-register state: pending (1 bit) and cnt (LAT_W bits).
- Issue is accepted when issue_valid_i & issue_regwrite_i & !stall_o & !flush_i & issue_rd_i != 0.
  - On accept: pending[rd] <= 1, cnt[rd] <= issue_lat_i.
- Countdown: every pending entry with cnt != 0 that is not being reloaded by an accepted issue decrements by 1 each cycle. cnt never wraps below 0.
- Writeback: if wb_valid_i and wb_rd_i != 0, pending[wb_rd_i] <= 0 and cnt[wb_rd_i] <= 0.
- Same register issued and written back in the same cycle: the issue wins, because the new producer supersedes the old one.
- stall_o is combinational on the current state:
  - stall_o = (id_use_rs1_i & id_rs1_i != 0 & pending[rs1] & cnt[rs1] != 0) | (the same term for rs2).
  - A pending entry with cnt = 0 does not stall; the forwarding path supplies the value.
- Issue while stalled: issue_valid_i with stall_o = 1 is ignored. The upstream control must drive issue_valid_i = 0 in that cycle, and the bench flags any violation.
- flush_i does not alter existing entries; already-issued instructions are non-speculative.
- stall_cnt_o increments on each cycle with stall_o = 1 and saturates at all-ones.

## Timing
- Reset: every pending and cnt cleared, busy_o = 0, stall_o = 0, stall_cnt_o = 0.
- Reset asserted mid-countdown clears all state on that edge. Any issue or writeback in the same cycle is discarded.
- Issue at edge t with lat L: a dependant in ID stalls during cycles t+1 … t+L and proceeds in cycle t+L+1.
- Load-use (L = 1) gives exactly one bubble. An ALU producer (L = 0) gives none.
- Writeback at edge t: busy_o bit falls at t+1.
- stall_o has zero-cycle latency from the id_* inputs.

## Structure
- hazard_pkg holds:
  - REG_W, NUM_REGS, LAT_W
  - named latency constants: LAT_ALU = 0, LAT_LOAD = 1, LAT_MUL = 3, LAT_DIV = 7
- Sub-module scoreboard_entry, instantiated NUM_REGS-1 times (x1..x31):
  - inputs: set, set_lat, clear, clk, rst
  - outputs: pending, wait_nz = pending & cnt != 0
  - implements the issue-over-writeback priority internally.
- The top level contains only the decode of the set/clear one-hots, the two read muxes producing stall_o, and the performance counter.

## Test plan
- Load x5 (lat 1) issued, next instruction uses rs1 = x5 → stall_o = 1 for exactly 1 cycle, then 0; stall_cnt_o = 1.
- ALU writes x7 (lat 0), next instruction reads x7 → stall_o never asserts; busy_o[7] = 1 until writeback.
- Divide into x9 (lat 7), dependant reads rs2 = x9 → 7 stall cycles; stall_cnt_o = 7; busy_o[9] clears 1 cycle after wb_rd_i = 9.
- Same-cycle issue to x3 (lat 2) and writeback of an older x3 → busy_o[3] stays 1; a dependant stalls 2 cycles.
- Issue with rd = 0 or flush_i = 1 → busy_o unchanged; a dependant on x0 never stalls.
- rst_i during a lat-5 countdown on x4 → next cycle busy_o = 0 and stall_o = 0 with the dependant still in ID; stall_cnt_o = 0.
